// File: rtl/rv_amo_pkg.sv
// Shared AMO definitions: funct5 opcodes, FSM states and request legality check.
// Optional macro RV_AMO_LRSC_EN makes LR/SC legal; otherwise they are rejected as illegal.
package rv_amo;

  typedef enum logic [4:0] {
    AMO_ADD  = 5'b00000,
    AMO_SWAP = 5'b00001,
    AMO_LR   = 5'b00010,
    AMO_SC   = 5'b00011,
    AMO_XOR  = 5'b00100,
    AMO_OR   = 5'b01000,
    AMO_AND  = 5'b01100,
    AMO_MIN  = 5'b10000,
    AMO_MAX  = 5'b10100,
    AMO_MINU = 5'b11000,
    AMO_MAXU = 5'b11100
  } amo_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_RESP
  } amo_state_e;

  function automatic logic amo_illegal(input logic [4:0] funct5, input logic dword,
                                       input logic [2:0] addr_lo, input int unsigned xlen);
    logic bad_op;
    case (funct5)
      AMO_ADD, AMO_SWAP, AMO_XOR, AMO_OR, AMO_AND,
      AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU: bad_op = 1'b0;
`ifdef RV_AMO_LRSC_EN
      AMO_LR, AMO_SC: bad_op = 1'b0;
`endif
      default: bad_op = 1'b1;
    endcase
    return bad_op || (dword && xlen == 32) ||
           (dword ? (addr_lo != 3'd0) : (addr_lo[1:0] != 2'd0));
  endfunction

endpackage

// File: rtl/rv_amo_alu.sv
// Combinational AMO compute: produces the value written back for a given op and width.
// Unaffected by RV_AMO_LRSC_EN; SC simply writes its operand like SWAP.
module rv_amo_alu
  import rv_amo::*;
#(
  parameter int XLEN = 32
) (
  input  amo_op_e           i_op,
  input  logic              i_dword,
  input  logic [XLEN-1:0]   i_old,
  input  logic [XLEN-1:0]   i_operand,
  output logic [XLEN-1:0]   o_result
);

  logic [31:0]     w_a32;
  logic [31:0]     w_b32;
  logic [31:0]     w_r32;
  logic [XLEN-1:0] w_rx;

  assign w_a32 = i_old[31:0];
  assign w_b32 = i_operand[31:0];

  // Both widths are evaluated; dword picks which one leaves the block.
  always_comb begin
    w_r32 = w_b32;
    w_rx  = i_operand;
    case (i_op)
      AMO_ADD: begin
        w_r32 = w_a32 + w_b32;
        w_rx  = i_old + i_operand;
      end
      AMO_XOR: begin
        w_r32 = w_a32 ^ w_b32;
        w_rx  = i_old ^ i_operand;
      end
      AMO_AND: begin
        w_r32 = w_a32 & w_b32;
        w_rx  = i_old & i_operand;
      end
      AMO_OR: begin
        w_r32 = w_a32 | w_b32;
        w_rx  = i_old | i_operand;
      end
      AMO_MIN: begin
        w_r32 = ($signed(w_a32) < $signed(w_b32)) ? w_a32 : w_b32;
        w_rx  = ($signed(i_old) < $signed(i_operand)) ? i_old : i_operand;
      end
      AMO_MAX: begin
        w_r32 = ($signed(w_a32) > $signed(w_b32)) ? w_a32 : w_b32;
        w_rx  = ($signed(i_old) > $signed(i_operand)) ? i_old : i_operand;
      end
      AMO_MINU: begin
        w_r32 = (w_a32 < w_b32) ? w_a32 : w_b32;
        w_rx  = (i_old < i_operand) ? i_old : i_operand;
      end
      AMO_MAXU: begin
        w_r32 = (w_a32 > w_b32) ? w_a32 : w_b32;
        w_rx  = (i_old > i_operand) ? i_old : i_operand;
      end
      default: begin
        w_r32 = w_b32;
        w_rx  = i_operand;
      end
    endcase
  end

  assign o_result = i_dword ? w_rx : XLEN'($signed(w_r32));

endmodule

// File: rtl/rv_amo_unit.sv
// Single-outstanding RISC-V atomic memory operation engine (read, compute, write, respond).
// Define RV_AMO_LRSC_EN to add LR/SC and the reservation register.
module rv_amo_unit
  import rv_amo::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [4:0]            req_funct5,
  input  logic                  req_dword,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]       req_data,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_write,
  output logic                  mem_dword,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [XLEN-1:0]       resp_data,
  output logic                  resp_err
);

  amo_state_e            r_state;
  amo_state_e            w_next;
  amo_op_e               r_op;
  logic                  r_dword;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [XLEN-1:0]       r_data;
  logic [XLEN-1:0]       r_old;
  logic [XLEN-1:0]       r_resp_data;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_illegal;
  logic                  w_req_sc;
  logic                  w_sc_hit;
  logic [XLEN-1:0]       w_rdata_ext;
  logic [XLEN-1:0]       w_result;

  assign w_illegal   = amo_illegal(req_funct5, req_dword, req_addr[2:0], XLEN);
  assign w_req_sc    = (req_funct5 == AMO_SC);
  assign w_accept    = req_valid && req_ready;
  assign w_rdata_ext = r_dword ? mem_rdata : XLEN'($signed(mem_rdata[31:0]));

`ifdef RV_AMO_LRSC_EN
  logic                  r_rsv_valid;
  logic [ADDR_WIDTH-1:0] r_rsv_addr;
  logic                  r_rsv_dword;

  assign w_sc_hit = r_rsv_valid && (r_rsv_addr == req_addr) && (r_rsv_dword == req_dword);
`else
  assign w_sc_hit = 1'b0;
`endif

  rv_amo_alu #(.XLEN(XLEN)) u_alu (
    .i_op      (r_op),
    .i_dword   (r_dword),
    .i_old     (r_old),
    .i_operand (r_data),
    .o_result  (w_result)
  );

  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    mem_valid  = 1'b0;
    mem_write  = 1'b0;
    resp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = rst;
        if (req_valid) begin
          if (w_illegal)     w_next = ST_RESP;
          else if (w_req_sc) w_next = w_sc_hit ? ST_WRITE : ST_RESP;
          else               w_next = ST_READ;
        end
      end
      ST_READ: begin
        mem_valid = 1'b1;
        if (mem_ready) w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rvalid) w_next = (r_op == AMO_LR) ? ST_RESP : ST_WRITE;
      end
      ST_WRITE: begin
        mem_valid = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) w_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_resp_data <= '0;
      r_err       <= 1'b0;
`ifdef RV_AMO_LRSC_EN
      r_rsv_valid <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_op    <= amo_op_e'(req_funct5);
          r_dword <= req_dword;
          r_addr  <= req_addr;
          r_data  <= req_data;
          r_err   <= w_illegal;
          // A failed SC answers 1 immediately; success answers 0 after its write.
          r_resp_data <= (!w_illegal && w_req_sc && !w_sc_hit) ? XLEN'(1) : '0;
`ifdef RV_AMO_LRSC_EN
          if (!w_illegal && w_req_sc) r_rsv_valid <= 1'b0;
`endif
        end
        ST_WAIT: if (mem_rvalid) begin
          r_old       <= w_rdata_ext;
          r_resp_data <= w_rdata_ext;
`ifdef RV_AMO_LRSC_EN
          if (r_op == AMO_LR) begin
            r_rsv_valid <= 1'b1;
            r_rsv_addr  <= r_addr;
            r_rsv_dword <= r_dword;
          end
`endif
        end
`ifdef RV_AMO_LRSC_EN
        // Any store landing on the reserved address breaks the reservation.
        ST_WRITE: if (mem_ready && r_rsv_valid && (r_rsv_addr == r_addr)) r_rsv_valid <= 1'b0;
`endif
        default: ;
      endcase
    end
  end

  assign mem_dword = r_dword;
  assign mem_addr  = r_addr;
  assign mem_wdata = w_result;
  assign resp_data = r_resp_data;
  assign resp_err  = r_err;

endmodule

// File: tb/tb_rv_amo_unit.sv
// Randomized bench for rv_amo_unit against a transaction-level model of memory and reservation.
// Honours RV_AMO_LRSC_EN the same way as the design (LR/SC legal only when defined).
module tb_rv_amo_unit;
  localparam int XLEN = 32;
  localparam int AW   = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [4:0]      req_funct5 = '0;
  logic            req_dword = 1'b0;
  logic [AW-1:0]   req_addr = '0;
  logic [XLEN-1:0] req_data = '0;
  logic            mem_valid, mem_write, mem_dword;
  logic            mem_ready, mem_rvalid;
  logic [AW-1:0]   mem_addr;
  logic [XLEN-1:0] mem_wdata, mem_rdata;
  logic            resp_valid, resp_err;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;

  always #5 clk = ~clk;

  rv_amo_unit #(.XLEN(XLEN), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct5(req_funct5),
    .req_dword(req_dword), .req_addr(req_addr), .req_data(req_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
    .mem_dword(mem_dword), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // memory seen by the DUT, and the model's own view of it
  logic [31:0] mem     [int];
  logic [31:0] ref_mem [int];
  bit fast = 1'b0;
  bit hold_wr = 1'b0;
  int wr_hs_cnt = 0;

  task automatic set_word(input int a, input logic [31:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  // memory + response-side driver
  initial begin
    bit rd_hs, wr_hs, rd_pend, rst_s;
    int rd_wait, rd_addr, wa;
    logic [31:0] wd;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; resp_ready = 1'b0;
    rd_pend = 0; rd_wait = 0; rd_addr = 0;
    forever begin
      @(negedge clk);
      rst_s = rst;
      rd_hs = rst && mem_valid && !mem_write && mem_ready;
      wr_hs = rst && mem_valid && mem_write && mem_ready;
      wa = int'(mem_addr);
      wd = mem_wdata;
      @(posedge clk); #1;
      if (!rst_s) rd_pend = 0;
      if (wr_hs) begin mem[wa] = wd; wr_hs_cnt++; end
      if (rd_hs) begin rd_pend = 1; rd_addr = wa; rd_wait = fast ? 0 : $urandom_range(0, 2); end
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (rd_pend) begin
        if (rd_wait == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem.exists(rd_addr) ? mem[rd_addr] : 32'hBAD0BAD0;
          rd_pend = 0;
        end else rd_wait--;
      end
      if (hold_wr) mem_ready = !mem_write;
      else         mem_ready = fast ? 1'b1 : 1'($urandom_range(0, 1));
      resp_ready = fast ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // transaction-level reference model
  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic        wr;
    int          addr;
    logic [31:0] wdata;
    logic [31:0] prev;
  } exp_t;

  exp_t cur;
  bit busy = 0, wr_seen = 0, resp_seen = 0;
  int cyc = 0, memv_cnt = 0;
  bit m_rv = 0;
  logic [31:0] m_ra = '0;
  logic m_rd = 1'b0;
  logic [31:0] last_resp, last_wdata;
  logic last_err, last_wr_seen;
  int last_lat, last_memv;

  task automatic model_accept(input logic [4:0] f, input logic d, input logic [31:0] a,
                              input logic [31:0] b);
    bit legal, hit;
    logic [31:0] old, res;
    cur = '{err: 1'b0, rdata: '0, wr: 1'b0, addr: int'(a), wdata: '0, prev: '0};
    legal = f inside {5'd0, 5'd1, 5'd4, 5'd8, 5'd12, 5'd16, 5'd20, 5'd24, 5'd28};
`ifdef RV_AMO_LRSC_EN
    if (f inside {5'd2, 5'd3}) legal = 1;
`endif
    if (!legal || d || a[1:0] != 2'd0) begin
      cur.err = 1'b1;
      return;
    end
    if (f == 5'd3) begin
      hit = m_rv && m_ra == a && m_rd == d;
      m_rv = 0;
      if (hit) begin
        cur.wr = 1'b1; cur.wdata = b; cur.prev = ref_mem[cur.addr]; ref_mem[cur.addr] = b;
      end else cur.rdata = 32'd1;
      return;
    end
    old = ref_mem[cur.addr];
    cur.rdata = old;
    if (f == 5'd2) begin
      m_rv = 1; m_ra = a; m_rd = d;
      return;
    end
    case (f)
      5'd0:    res = old + b;
      5'd4:    res = old ^ b;
      5'd12:   res = old & b;
      5'd8:    res = old | b;
      5'd16:   res = ($signed(old) < $signed(b)) ? old : b;
      5'd20:   res = ($signed(old) > $signed(b)) ? old : b;
      5'd24:   res = (old < b) ? old : b;
      5'd28:   res = (old > b) ? old : b;
      default: res = b;
    endcase
    cur.wr = 1'b1; cur.wdata = res; cur.prev = old;
    ref_mem[cur.addr] = res;
    if (m_rv && m_ra == a) m_rv = 0;
  endtask

  // compare process: checks memory and response ports every cycle
  initial begin
    logic pv_valid, pv_ready, pv_write;
    logic [31:0] pv_addr, pv_wdata;
    pv_valid = 0; pv_ready = 0; pv_write = 0; pv_addr = '0; pv_wdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (busy && cur.wr && !wr_seen) ref_mem[cur.addr] = cur.prev;
        busy = 0; m_rv = 0; pv_valid = 0;
      end else begin
        if (busy) cyc++;
        if (mem_valid) begin
          memv_cnt++;
          if (!busy || cur.err) chk("mem_access_unexpected", 1, 0);
          else if (mem_write) begin
            if (!cur.wr) chk("mem_write_unexpected", 1, 0);
            else if (mem_ready) begin
              chk("wr_addr", mem_addr, cur.addr);
              chk("wr_data", mem_wdata, cur.wdata);
              chk("wr_dword", mem_dword, 0);
              wr_seen = 1; last_wdata = mem_wdata;
            end
          end else if (mem_ready) chk("rd_addr", mem_addr, cur.addr);
          if (pv_valid && !pv_ready) begin
            chk("hold_addr", mem_addr, pv_addr);
            chk("hold_wdata", mem_wdata, pv_wdata);
            chk("hold_write", mem_write, pv_write);
          end
        end else if (pv_valid && !pv_ready) chk("mem_valid_dropped", 0, 1);
        pv_valid = mem_valid; pv_ready = mem_ready; pv_write = mem_write;
        pv_addr = mem_addr; pv_wdata = mem_wdata;
        if (resp_valid) begin
          if (!busy) chk("resp_unexpected", 1, 0);
          else begin
            if (!resp_seen) begin resp_seen = 1; last_lat = cyc; end
            if (resp_ready) begin
              chk("resp_data", resp_data, cur.rdata);
              chk("resp_err", resp_err, cur.err);
              chk("write_done", wr_seen, cur.wr);
              last_resp = resp_data; last_err = resp_err;
              last_wr_seen = wr_seen; last_memv = memv_cnt;
              busy = 0;
            end
          end
        end
        if (req_valid && req_ready) begin
          model_accept(req_funct5, req_dword, req_addr, req_data);
          busy = 1; cyc = 0; memv_cnt = 0; wr_seen = 0; resp_seen = 0;
        end
      end
    end
  end

  task automatic send(input logic [4:0] f, input logic d, input logic [31:0] a,
                      input logic [31:0] b, output bit ok);
    @(posedge clk); #1;
    req_valid = 1'b1; req_funct5 = f; req_dword = d; req_addr = a; req_data = b;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_data = $urandom; req_addr = $urandom; req_funct5 = 5'($urandom);
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic do_txn(input logic [4:0] f, input logic d, input logic [31:0] a,
                        input logic [31:0] b);
    bit ok, done;
    send(f, d, a, b, ok);
    if (ok) begin
      done = 0;
      for (int i = 0; i < 300 && !done; i++) begin
        @(posedge clk);
        if (!busy) done = 1;
      end
      if (!done) chk("resp_timeout", 0, 1);
    end
  endtask

  logic [4:0] ops [11] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd8, 5'd12, 5'd16, 5'd20, 5'd24, 5'd28};
  logic [31:0] edge_vals [5] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};

  initial begin
    bit ok;
    int w0;
    logic [4:0] f;
    logic [31:0] a, b, lr_a;
    bit last_lr;
    for (int i = 0; i < 64; i += 4) set_word(i, $urandom);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_err", resp_err, 0);
    @(posedge clk); #1 rst = 1'b1;

    fast = 1;
    set_word(32'h10, 32'h7FFFFFFF);
    last_wdata = '0;
    do_txn(5'd0, 0, 32'h10, 32'h1);
    chk("add_wdata", last_wdata, 32'h80000000);
    chk("add_resp", last_resp, 32'h7FFFFFFF);
    chk("add_latency", last_lat, 4);

    set_word(32'h18, 32'hFFFFFFFF);
    last_wdata = '0;
    do_txn(5'd16, 0, 32'h18, 32'h1);
    chk("min_wdata", last_wdata, 32'hFFFFFFFF);
    set_word(32'h18, 32'hFFFFFFFF);
    do_txn(5'd24, 0, 32'h18, 32'h1);
    chk("minu_wdata", last_wdata, 32'h00000001);

`ifdef RV_AMO_LRSC_EN
    set_word(32'h20, 32'h1234);
    do_txn(5'd2, 0, 32'h20, 32'h0);
    chk("lr_resp", last_resp, 32'h1234);
    do_txn(5'd3, 0, 32'h20, 32'hABCD);
    chk("sc1_resp", last_resp, 0);
    chk("sc1_write", last_wr_seen, 1);
    chk("sc1_mem", mem[32'h20], 32'hABCD);
    do_txn(5'd3, 0, 32'h20, 32'h5555);
    chk("sc2_resp", last_resp, 1);
    chk("sc2_nowrite", last_wr_seen, 0);
`else
    do_txn(5'd2, 0, 32'h20, 32'h0);
    chk("lr_illegal", last_err, 1);
    do_txn(5'd3, 0, 32'h20, 32'h0);
    chk("sc_illegal", last_err, 1);
`endif

    do_txn(5'd1, 0, 32'h22, 32'h9);
    chk("swap_misaligned_err", last_err, 1);
    chk("swap_misaligned_nomem", last_memv, 0);
    do_txn(5'd0, 1, 32'h28, 32'h9);
    chk("add_d_err", last_err, 1);
    chk("add_d_resp", last_resp, 0);

    // reset while stalled in WRITE
`ifdef RV_AMO_LRSC_EN
    do_txn(5'd2, 0, 32'h30, 32'h0);
`endif
    hold_wr = 1;
    send(5'd0, 0, 32'h14, 32'h5, ok);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (mem_valid && mem_write) ok = 1;
    end
    chk("reach_write", ok, 1);
    w0 = wr_hs_cnt;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_write_mem_valid", mem_valid, 0);
    chk("rst_in_write_resp_valid", resp_valid, 0);
    chk("rst_in_write_req_ready", req_ready, 0);
    @(posedge clk); #1 rst = 1'b1; hold_wr = 0;
    @(negedge clk);
    chk("idle_after_reset", req_ready, 1);
    chk("no_write_after_reset", wr_hs_cnt, w0);
`ifdef RV_AMO_LRSC_EN
    do_txn(5'd3, 0, 32'h30, 32'h7);
    chk("rsv_cleared_by_reset", last_resp, 1);
`endif

    // randomized traffic
    fast = 0;
    last_lr = 0; lr_a = '0;
    for (int n = 0; n < 250; n++) begin
      f = ($urandom_range(0, 9) == 0) ? 5'($urandom) : ops[$urandom_range(0, 10)];
      a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 63)) : 32'($urandom_range(0, 15)) * 4;
      b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom;
      if (last_lr && $urandom_range(0, 1) == 1) begin f = 5'd3; a = lr_a; end
      last_lr = (f == 5'd2); lr_a = a;
      do_txn(f, ($urandom_range(0, 11) == 0), a, b);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

endmodule
